// File: rtl/sha256_ctrl.sv
// sha256_ctrl: top-level sequencer for the SHA-256 core.
// Gates host words into the block buffer, then runs the compression core
// through LOAD and NUM_ROUNDS rounds. It then commits the result into
// prev_hash and either rearms for the next block or flags the digest valid.
module sha256_ctrl #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int NUM_ROUNDS      = 64,
    localparam int RW             = $clog2(NUM_ROUNDS),
    localparam int WW             = $clog2(WORDS_PER_BLOCK)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          data_valid,
    input  logic          last_block,
    output logic          ready,
    output logic          data_rcv,
    output logic          clear,
    output logic          reset_hash,
    output logic          sample_hash,
    output logic          load,
    output logic          round_en,
    output logic [RW-1:0] round_idx,
    output logic          busy,
    output logic          hash_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RECV   = 3'd2,
        LOAD   = 3'd3,
        ROUND  = 3'd4,
        UPDATE = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS_PER_BLOCK - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    state_t        state, state_nxt;
    logic [WW-1:0] word_cnt;
    logic          last_q;

    logic last_word_acc;
    logic last_round;

    assign last_word_acc = (state == RECV) && data_valid && (word_cnt == LAST_WORD);
    assign last_round    = (state == ROUND) && (round_idx == LAST_ROUND);

    // State register.
    // NOTE: sequential state is updated with non-blocking (<=) assignments so
    // every flop samples its inputs from before the edge, independent of the
    // order in which the always blocks are evaluated.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word/round counters and the end-of-message flag captured with the last word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_cnt  <= '0;
            round_idx <= '0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                INIT: word_cnt <= '0;
                RECV: begin
                    if (last_word_acc) begin
                        word_cnt <= '0;
                        last_q   <= last_block;
                    end else if (data_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                LOAD: round_idx <= '0;
                ROUND: begin
                    if (last_round) begin
                        round_idx <= '0;
                    end else begin
                        round_idx <= round_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and Moore decode of the strobes.
    // NOTE: every signal written here gets a default before the case; a path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        data_rcv    = 1'b0;
        clear       = 1'b0;
        reset_hash  = 1'b0;
        sample_hash = 1'b0;
        load        = 1'b0;
        round_en    = 1'b0;
        hash_valid  = 1'b0;
        busy        = (state != IDLE) && (state != DONE);

        case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                reset_hash = 1'b1;
                clear      = 1'b1;
                state_nxt  = RECV;
            end
            RECV: begin
                ready    = 1'b1;
                data_rcv = data_valid;
                if (last_word_acc) state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                if (last_round) state_nxt = UPDATE;
            end
            UPDATE: begin
                sample_hash = 1'b1;
                if (last_q) begin
                    state_nxt = DONE;
                end else begin
                    // The next block starts from an empty buffer.
                    clear     = 1'b1;
                    state_nxt = RECV;
                end
            end
            DONE: begin
                hash_valid = 1'b1;
                if (start) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: directed, table-driven bench for the SHA-256 sequencer.
// Each vector is one clock cycle. Inputs change 1 time unit after the rising edge.
// Outputs are compared on the falling edge.
module tb_sha256_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       data_valid = 1'b0;
    logic       last_block = 1'b0;
    logic       ready, data_rcv, clear, reset_hash, sample_hash;
    logic       load, round_en, busy, hash_valid;
    logic [5:0] round_idx;

    always #5 clk = ~clk;

    sha256_ctrl dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .data_valid (data_valid),
        .last_block (last_block),
        .ready      (ready),
        .data_rcv   (data_rcv),
        .clear      (clear),
        .reset_hash (reset_hash),
        .sample_hash(sample_hash),
        .load       (load),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .busy       (busy),
        .hash_valid (hash_valid)
    );

    // Output flag vector: {ready,data_rcv,clear,reset_hash,sample_hash,load,round_en,busy,hash_valid}
    localparam logic [8:0] B_READY = 9'h100;
    localparam logic [8:0] B_RCV   = 9'h080;
    localparam logic [8:0] B_CLEAR = 9'h040;
    localparam logic [8:0] B_RHASH = 9'h020;
    localparam logic [8:0] B_SHASH = 9'h010;
    localparam logic [8:0] B_LOAD  = 9'h008;
    localparam logic [8:0] B_RND   = 9'h004;
    localparam logic [8:0] B_BUSY  = 9'h002;
    localparam logic [8:0] B_HV    = 9'h001;

    localparam logic [8:0] F_IDLE  = 9'h000;
    localparam logic [8:0] F_INIT  = B_CLEAR | B_RHASH | B_BUSY;
    localparam logic [8:0] F_RECV  = B_READY | B_BUSY;
    localparam logic [8:0] F_RCV   = B_READY | B_RCV | B_BUSY;
    localparam logic [8:0] F_LOAD  = B_LOAD | B_BUSY;
    localparam logic [8:0] F_ROUND = B_RND | B_BUSY;
    localparam logic [8:0] F_UPD   = B_SHASH | B_BUSY;
    localparam logic [8:0] F_UPDC  = B_SHASH | B_CLEAR | B_BUSY;
    localparam logic [8:0] F_DONE  = B_HV;

    typedef struct {
        logic       st;
        logic       dv;
        logic       lb;
        logic [8:0] flags;
        logic [5:0] idx;
        string      name;
    } vec_t;

    vec_t vecs[$];

    logic [8:0] act_flags;
    assign act_flags = {ready, data_rcv, clear, reset_hash, sample_hash,
                        load, round_en, busy, hash_valid};

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc_no = 0;
    int rcv_cnt = 0;

    // Counts buffer write strobes seen at each rising edge.
    always @(posedge clk) begin
        if (data_rcv === 1'b1) rcv_cnt <= rcv_cnt + 1;
    end

    task automatic check_out(input string name, input logic [8:0] exp_f, input logic [5:0] exp_i);
        chk_cnt++;
        if (act_flags === exp_f && round_idx === exp_i) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @cycle %0d: flags=%b idx=%0d, required flags=%b idx=%0d",
                     name, cyc_no, act_flags, round_idx, exp_f, exp_i);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        chk_cnt++;
        if (act == exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, compare on the falling edge, advance past the next rising edge.
    task automatic cyc(input logic st, input logic dv, input logic lb, input string name,
                       input logic [8:0] f, input logic [5:0] i);
        start      = st;
        data_valid = dv;
        last_block = lb;
        @(negedge clk);
        check_out(name, f, i);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // A full block from RECV: 8 words, LOAD, 64 rounds, UPDATE.
    task automatic run_block(input logic lb);
        for (int w = 0; w < 8; w++) cyc(1'b0, 1'b1, (w == 7) ? lb : 1'b0, "blk_word", F_RCV, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, "blk_load", F_LOAD, 6'd0);
        for (int r = 0; r < 64; r++) cyc(1'b0, 1'b0, 1'b0, "blk_round", F_ROUND, 6'(r));
        cyc(1'b0, 1'b0, 1'b0, lb ? "blk_update_last" : "blk_update_more", lb ? F_UPD : F_UPDC, 6'd0);
    endtask

    initial begin
        int w8_edge;
        int rcv_base;

        // Vectors: idle, start, INIT, paused word stream, LOAD/ROUND with ignored events.
        vecs.push_back('{1'b0, 1'b1, 1'b0, F_IDLE,  6'd0, "idle_dv_drop"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, F_IDLE,  6'd0, "idle_start"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, F_INIT,  6'd0, "init"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, F_RCV,   6'd0, "w1"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, F_RCV,   6'd0, "w2_lb_ignored"});
        for (int p = 0; p < 4; p++) vecs.push_back('{1'b0, 1'b0, 1'b0, F_RECV, 6'd0, "pause"});
        for (int w = 3; w < 8; w++) vecs.push_back('{1'b0, 1'b1, 1'b0, F_RCV, 6'd0, "w3_7"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, F_RCV,   6'd0, "w8"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, F_LOAD,  6'd0, "load_ign"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, F_ROUND, 6'd0, "r0_start_ign"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, F_ROUND, 6'd1, "r1_dv_ign"});

        // Reset held for two cycles: every output low.
        @(negedge clk);
        check_out("reset", F_IDLE, 6'd0);
        @(posedge clk);
        @(negedge clk);
        check_out("reset2", F_IDLE, 6'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, "idle_hold", F_IDLE, 6'd0);

        // Single block with paused input and ignored events.
        rcv_base = rcv_cnt;
        w8_edge  = 0;
        foreach (vecs[k]) begin
            cyc(vecs[k].st, vecs[k].dv, vecs[k].lb, vecs[k].name, vecs[k].flags, vecs[k].idx);
            if (vecs[k].name == "w8") w8_edge = cyc_no;
        end
        for (int r = 2; r < 64; r++)
            cyc(r == 10, r == 20, 1'b0, "round_seq", F_ROUND, 6'(r));
        cyc(1'b0, 1'b0, 1'b0, "update_last", F_UPD, 6'd0);
        check_int("hash_valid_latency", cyc_no - w8_edge, 66);
        check_int("data_rcv_pulses", rcv_cnt - rcv_base, 8);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, "done_hold", F_DONE, 6'd0);
        cyc(1'b1, 1'b1, 1'b0, "done_start", F_DONE, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, "restart_init", F_INIT, 6'd0);

        // Two-block message: first UPDATE rearms with clear, no reset_hash.
        run_block(1'b0);
        cyc(1'b0, 1'b0, 1'b0, "between_blocks", F_RECV, 6'd0);
        run_block(1'b1);
        cyc(1'b0, 1'b0, 1'b0, "two_block_done", F_DONE, 6'd0);

        // Reset asserted mid-ROUND at round_idx 30.
        cyc(1'b1, 1'b0, 1'b0, "t6_start", F_DONE, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, "t6_init", F_INIT, 6'd0);
        for (int w = 0; w < 8; w++) cyc(1'b0, 1'b1, w == 7, "t6_word", F_RCV, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, "t6_load", F_LOAD, 6'd0);
        for (int r = 0; r < 30; r++) cyc(1'b0, 1'b0, 1'b0, "t6_round", F_ROUND, 6'(r));
        @(negedge clk);
        check_out("t6_round30", F_ROUND, 6'd30);
        n_rst = 1'b0;
        #1;
        check_out("rst_mid_round", F_IDLE, 6'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "after_rst_idle", F_IDLE, 6'd0);
        cyc(1'b1, 1'b0, 1'b0, "fresh_start", F_IDLE, 6'd0);
        cyc(1'b0, 1'b0, 1'b0, "fresh_init", F_INIT, 6'd0);
        run_block(1'b1);
        cyc(1'b0, 1'b0, 1'b0, "fresh_done", F_DONE, 6'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
